// File: rtl/imem_loader.sv
// Byte-stream loader that fills instruction memory while holding the CPU.
// Optional trailing checksum enabled by defining IMEM_LOADER_CHECKSUM_EN.
`ifndef ISIZE
`define ISIZE 16
`endif
`ifndef DSIZE
`define DSIZE 16
`endif

module imem_loader #(
  parameter logic [`ISIZE-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_wen,
  output logic [`ISIZE-1:0] mem_addr,
  output logic [`DSIZE-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CSUM_HI, CSUM_LO,
`endif
    DONE
  } state_t;

  localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

  state_t            state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [15:0]       k_q, k_d;
  logic [7:0]        hi_q, hi_d;
  logic [`ISIZE-1:0] addr_q, addr_d;
  logic [`DSIZE-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [15:0]       len_w;
  logic              rdy, xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [15:0]       csum_q, csum_d;
`endif

  always_comb begin
    rdy = (state_q == LEN_HI) || (state_q == LEN_LO) ||
          (state_q == DAT_HI) || (state_q == DAT_LO)
`ifdef IMEM_LOADER_CHECKSUM_EN
          || (state_q == CSUM_HI) || (state_q == CSUM_LO)
`endif
          ;
  end

  assign xfer  = byte_valid && rdy;
  assign len_w = {n_q[15:8], byte_data};

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d = LEN_HI;
        err_d   = 1'b0;
        k_d     = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = '0;
`endif
      end
      LEN_HI: if (xfer) begin
        n_d     = {byte_data, n_q[7:0]};
        state_d = LEN_LO;
      end
      LEN_LO: if (xfer) begin
        n_d = len_w;
        if (len_w == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CSUM_HI;
`else
          state_d = DONE;
`endif
        end else if ({1'b0, len_w} > MAX_W) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = DAT_HI;
        end
      end
      DAT_HI: if (xfer) begin
        hi_d    = byte_data;
        state_d = DAT_LO;
      end
      // Address and data are latched here so they stay put after the write.
      DAT_LO: if (xfer) begin
        addr_d  = BASE_ADDR + `ISIZE'(k_q);
        wdata_d = `DSIZE'({hi_q, byte_data});
        state_d = WRITE;
      end
      WRITE: begin
        k_d = k_q + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d = csum_q + wdata_q[15:0];
        state_d = (k_q + 16'd1 == n_q) ? CSUM_HI : DAT_HI;
`else
        state_d = (k_q + 16'd1 == n_q) ? DONE : DAT_HI;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM_HI: if (xfer) begin
        hi_d    = byte_data;
        state_d = CSUM_LO;
      end
      CSUM_LO: if (xfer) begin
        if ({hi_q, byte_data} != csum_q) err_d = 1'b1;
        state_d = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      k_q     <= '0;
      hi_q    <= '0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Gating with rst suppresses a write or hold in the very cycle reset is asserted.
  assign byte_ready = rdy && !rst;
  assign mem_wen    = (state_q == WRITE) && !rst;
  assign cpu_hold   = (state_q != IDLE) && !rst;
  assign done       = (state_q == DONE) && !rst;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign err        = err_q;

endmodule
